// File: rtl/csa_arbiter_if.sv
// Request/result bundle between two adder requesters, the arbiter and the result consumer.
// The arbiter sits on the slave modport; the requester/consumer side uses master.
interface csa_arbiter_if #(
  parameter int WIDTH = 64
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;
  logic             req0_chain;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;
  logic             req1_chain;

  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_last;
  logic             lock_abort;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin, req0_chain,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cin, req1_chain,
    output req1_ready,
    output res_valid, res_id, res_sum, res_cout, res_last, lock_abort,
    input  res_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin, req0_chain,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cin, req1_chain,
    input  req1_ready,
    input  res_valid, res_id, res_sum, res_cout, res_last, lock_abort,
    output res_ready
  );
endinterface

// File: rtl/csa_arbiter.sv
// Round-robin arbiter sharing one carry-select adder between two requesters,
// with grant locking for multi-beat chained adds and a lock timeout.
module csa_adder #(
  parameter int WIDTH = 64,
  parameter int BLOCK = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NBLK = WIDTH / BLOCK;

  logic [NBLK:0] carry;

  assign carry[0] = cin;

  // Each block precomputes both carry-in cases; the incoming carry only selects.
  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    logic [BLOCK:0] sum0;
    logic [BLOCK:0] sum1;

    assign sum0 = {1'b0, a[i*BLOCK +: BLOCK]} + {1'b0, b[i*BLOCK +: BLOCK]};
    assign sum1 = {1'b0, a[i*BLOCK +: BLOCK]} + {1'b0, b[i*BLOCK +: BLOCK]} + (BLOCK+1)'(1);
    assign sum[i*BLOCK +: BLOCK] = carry[i] ? sum1[BLOCK-1:0] : sum0[BLOCK-1:0];
    assign carry[i+1] = carry[i] ? sum1[BLOCK] : sum0[BLOCK];
  end

  assign cout = carry[NBLK];
endmodule

module csa_arbiter #(
  parameter int WIDTH        = 64,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  csa_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOCK0,
    S_LOCK1
  } state_e;

  state_e           state_q, state_d;
  logic             carry_q, carry_d;
  logic             last_grant_q, last_grant_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_cout_q, res_cout_d;
  logic             res_last_q, res_last_d;

  logic             out_free;
  logic             grant;
  logic             grant_en;
  logic             xfer;
  logic             idle_cycle;
  logic             abort;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             cin_sel;
  logic             chain_sel;
  logic             cin_eff;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  csa_adder #(.WIDTH(WIDTH), .BLOCK(16)) u_adder (
    .a    (a_sel),
    .b    (b_sel),
    .cin  (cin_eff),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    out_free = !res_valid_q || bus.res_ready;
    grant    = 1'b0;
    grant_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          grant_en = 1'b1;
          grant    = !last_grant_q;
        end else if (bus.req0_valid) begin
          grant_en = 1'b1;
          grant    = 1'b0;
        end else if (bus.req1_valid) begin
          grant_en = 1'b1;
          grant    = 1'b1;
        end
      end
      S_LOCK0: begin
        grant    = 1'b0;
        grant_en = bus.req0_valid;
      end
      S_LOCK1: begin
        grant    = 1'b1;
        grant_en = bus.req1_valid;
      end
      default: begin
        grant    = 1'b0;
        grant_en = 1'b0;
      end
    endcase

    // rst_n gating keeps the readys low for the whole time reset is held.
    xfer           = grant_en && out_free && rst_n;
    bus.req0_ready = xfer && !grant;
    bus.req1_ready = xfer && grant;

    a_sel     = grant ? bus.req1_a     : bus.req0_a;
    b_sel     = grant ? bus.req1_b     : bus.req0_b;
    cin_sel   = grant ? bus.req1_cin   : bus.req0_cin;
    chain_sel = grant ? bus.req1_chain : bus.req0_chain;
    cin_eff   = (state_q == S_IDLE) ? cin_sel : carry_q;

    // A locked owner stalled only by a full output register is not idle.
    idle_cycle = (state_q != S_IDLE) && !grant_en;
    abort      = idle_cycle && (cnt_q == 8'(LOCK_TIMEOUT - 1));

    state_d      = state_q;
    carry_d      = carry_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    res_sum_d    = res_sum_q;
    res_cout_d   = res_cout_q;
    res_last_d   = res_last_q;

    if (xfer) begin
      res_valid_d = 1'b1;
      res_id_d    = grant;
      res_sum_d   = add_sum;
      res_cout_d  = add_cout;
      res_last_d  = !chain_sel;
      cnt_d       = 8'd0;
      if (chain_sel) begin
        state_d = grant ? S_LOCK1 : S_LOCK0;
        carry_d = add_cout;
      end else begin
        state_d      = S_IDLE;
        carry_d      = 1'b0;
        last_grant_d = grant;
      end
    end else begin
      if (bus.res_ready) begin
        res_valid_d = 1'b0;
      end
      if (abort) begin
        state_d      = S_IDLE;
        carry_d      = 1'b0;
        cnt_d        = 8'd0;
        last_grant_d = (state_q == S_LOCK1);
      end else if (idle_cycle) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      carry_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 8'd0;
      res_valid_q  <= 1'b0;
      res_id_q     <= 1'b0;
      res_sum_q    <= '0;
      res_cout_q   <= 1'b0;
      res_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      carry_q      <= carry_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_sum_q    <= res_sum_d;
      res_cout_q   <= res_cout_d;
      res_last_q   <= res_last_d;
    end
  end

  assign bus.res_valid  = res_valid_q;
  assign bus.res_id     = res_id_q;
  assign bus.res_sum    = res_sum_q;
  assign bus.res_cout   = res_cout_q;
  assign bus.res_last   = res_last_q;
  assign bus.lock_abort = abort;
endmodule

// File: tb/tb_csa_arbiter.sv
// Self-checking bench for csa_arbiter: directed scenarios then randomized traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_csa_arbiter;
  localparam int LOCK_TO = 15;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  csa_arbiter_if #(.WIDTH(64)) bus ();

  csa_arbiter #(.WIDTH(64), .LOCK_TIMEOUT(LOCK_TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic        v  [2];
  logic [63:0] a  [2];
  logic [63:0] b  [2];
  logic        ci [2];
  logic        ch [2];
  logic        rr;

  assign bus.req0_valid = v[0];
  assign bus.req0_a     = a[0];
  assign bus.req0_b     = b[0];
  assign bus.req0_cin   = ci[0];
  assign bus.req0_chain = ch[0];
  assign bus.req1_valid = v[1];
  assign bus.req1_a     = a[1];
  assign bus.req1_b     = b[1];
  assign bus.req1_cin   = ci[1];
  assign bus.req1_chain = ch[1];
  assign bus.res_ready  = rr;

  // Reference model: who owns an open chain (-1 = nobody), its carry, who won
  // the last completed operation, idle cycles seen by the owner, and the result slot.
  int          owner;
  int          last_g;
  int          idle;
  bit          carry;
  bit          m_ov;
  bit          m_id;
  logic [63:0] m_sum;
  bit          m_cout;
  bit          m_last;
  bit          er [2];

  int compared   = 0;
  int mismatched = 0;

  task automatic check_output(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner  = -1;
    last_g = 1;
    idle   = 0;
    carry  = 1'b0;
    m_ov   = 1'b0;
    er[0]  = 1'b0;
    er[1]  = 1'b0;
  endtask

  task automatic set_req(input int k, input logic val, input logic [63:0] aa,
                         input logic [63:0] bb, input logic c, input logic chn);
    v[k]  = val;
    a[k]  = aa;
    b[k]  = bb;
    ci[k] = c;
    ch[k] = chn;
  endtask

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    case ($urandom_range(3))
      0:       w = '1;
      1:       w = '0;
      default: w = {$urandom, $urandom};
    endcase
    return w;
  endfunction

  // Checks the cycle's outputs against the model, advances the model, ends on the next negedge.
  task automatic step();
    bit          free;
    bit          abort;
    bit          counted;
    int          win;
    bit          cin_eff;
    logic [64:0] full;
    #1;
    free    = !m_ov || rr;
    win     = -1;
    abort   = 1'b0;
    counted = 1'b0;
    if (owner < 0) begin
      if (free) begin
        if (v[0] && v[1]) win = 1 - last_g;
        else if (v[0])    win = 0;
        else if (v[1])    win = 1;
      end
    end else if (v[owner]) begin
      if (free) win = owner;
    end else begin
      counted = 1'b1;
      abort   = (idle + 1 == LOCK_TO);
    end

    check_output("ready0", bus.req0_ready, (win == 0));
    check_output("ready1", bus.req1_ready, (win == 1));
    check_output("lock_abort", bus.lock_abort, abort);
    check_output("res_valid", bus.res_valid, m_ov);
    if (m_ov) begin
      check_output("res_id", bus.res_id, m_id);
      check_output("res_sum", bus.res_sum, m_sum);
      check_output("res_cout", bus.res_cout, m_cout);
      check_output("res_last", bus.res_last, m_last);
    end

    if (win >= 0) begin
      cin_eff = (owner < 0) ? ci[win] : carry;
      full    = {1'b0, a[win]} + {1'b0, b[win]} + 65'(cin_eff);
      m_ov    = 1'b1;
      m_id    = win[0];
      m_sum   = full[63:0];
      m_cout  = full[64];
      m_last  = !ch[win];
      idle    = 0;
      if (ch[win]) begin
        owner = win;
        carry = full[64];
      end else begin
        owner  = -1;
        last_g = win;
        carry  = 1'b0;
      end
    end else begin
      if (rr) m_ov = 1'b0;
      if (abort) begin
        last_g = owner;
        owner  = -1;
        carry  = 1'b0;
        idle   = 0;
      end else if (counted) begin
        idle++;
      end
    end
    er[0] = (win == 0);
    er[1] = (win == 1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    rr    = 1'b1;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_output("rst_res_valid", bus.res_valid, 1'b0);
    check_output("rst_res_sum", bus.res_sum, 64'd0);
    check_output("rst_lock_abort", bus.lock_abort, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single beat on req0");
    set_req(0, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, 0);
    step();
    set_req(0, 0, 0, 0, 0, 0);
    check_output("t1_sum", bus.res_sum, 64'h0000_0001_0000_0000);
    check_output("t1_cout", bus.res_cout, 1'b0);
    check_output("t1_last", bus.res_last, 1'b1);
    check_output("t1_id", bus.res_id, 1'b0);
    step();

    $display("[TB] alternating grants");
    set_req(0, 1, 64'h10, 64'h20, 0, 0);
    set_req(1, 1, 64'h100, 64'h200, 1, 0);
    repeat (8) step();
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    step();

    $display("[TB] chained 128-bit add on req1");
    set_req(1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 1);
    step();
    check_output("chain_b1_sum", bus.res_sum, 64'd0);
    check_output("chain_b1_cout", bus.res_cout, 1'b1);
    check_output("chain_b1_last", bus.res_last, 1'b0);
    set_req(0, 1, 64'd5, 64'd6, 0, 0);
    set_req(1, 1, 64'd0, 64'd0, 0, 0);
    step();
    check_output("chain_b2_sum", bus.res_sum, 64'd1);
    check_output("chain_b2_cout", bus.res_cout, 1'b0);
    check_output("chain_b2_last", bus.res_last, 1'b1);
    set_req(1, 0, 0, 0, 0, 0);
    step();
    set_req(0, 0, 0, 0, 0, 0);
    step();

    $display("[TB] output backpressure");
    set_req(0, 1, 64'd3, 64'd4, 0, 0);
    set_req(1, 1, 64'd7, 64'd8, 0, 0);
    step();
    rr = 1'b0;
    repeat (3) step();
    rr = 1'b1;
    repeat (3) step();
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    step();

    $display("[TB] lock timeout");
    set_req(0, 1, 64'd7, 64'd8, 0, 1);
    step();
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 1, 64'd9, 64'd9, 0, 0);
    repeat (LOCK_TO - 1) step();
    #1;
    check_output("timeout_pulse", bus.lock_abort, 1'b1);
    step();
    step();
    set_req(1, 0, 0, 0, 0, 0);
    step();

    $display("[TB] reset while locked");
    set_req(1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
    step();
    set_req(0, 1, 64'd1, 64'd2, 0, 0);
    rst_n = 1'b0;
    #1;
    check_output("rst_mid_valid", bus.res_valid, 1'b0);
    check_output("rst_mid_ready0", bus.req0_ready, 1'b0);
    check_output("rst_mid_ready1", bus.req1_ready, 1'b0);
    check_output("rst_mid_abort", bus.lock_abort, 1'b0);
    check_output("rst_mid_sum", bus.res_sum, 64'd0);
    check_output("rst_mid_id", bus.res_id, 1'b0);
    check_output("rst_mid_cout", bus.res_cout, 1'b0);
    check_output("rst_mid_last", bus.res_last, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_req(1, 1, 64'd3, 64'd4, 0, 0);
    #1;
    check_output("rst_first_grant", bus.req0_ready, 1'b1);
    step();
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    step();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 900; i++) begin
      int pv;
      case ((i / 150) % 3)
        0:       pv = 85;
        1:       pv = 25;
        default: pv = 4;
      endcase
      for (int k = 0; k < 2; k++) begin
        if (!(v[k] && !er[k])) begin
          v[k]  = ($urandom_range(99) < pv);
          a[k]  = rand_word();
          b[k]  = rand_word();
          ci[k] = $urandom_range(1);
          ch[k] = ($urandom_range(99) < 40);
        end
      end
      rr = ($urandom_range(99) < 75);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
